// File: rtl/s2p_pkg.sv
// Shared types and defaults for the serial-to-parallel receiver.
package s2p_pkg;

  localparam int S2P_DEFAULT_WIDTH = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } s2p_state_t;

endpackage

// File: rtl/s2p_hold_reg.sv
// Valid/ready output holding register: loads completed words, hands them to the
// consumer, and flags a sticky overrun when a word arrives with no room for it.
module s2p_hold_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             xfer;
  logic             dropEvent;

  // A transfer in the same cycle as a load frees the slot for the new word,
  // so only a load into a slot that stays occupied counts as an overrun.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    dropEvent = 1'b0;
    xfer      = valid_q & ready_i;
    if (load_i) begin
      if (!valid_q || xfer) begin
        data_d  = data_i;
        valid_d = 1'b1;
      end else begin
        dropEvent = 1'b1;
      end
    end else if (xfer) begin
      valid_d = 1'b0;
    end
    if (dropEvent) begin
      overrun_d = 1'b1;
    end else if (clr_i) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/serial_to_parallel.sv
// LSB-first serial receiver: shifts strobed bits in at the MSB and presents each
// WIDTH-bit group on a valid/ready port with sticky overrun reporting.
module serial_to_parallel
  import s2p_pkg::*;
#(
  parameter int WIDTH = S2P_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             out_ready,
  input  logic             overrun_clr,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  s2p_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             wordDone;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    wordDone = 1'b0;
    if (serial_valid) begin
      sh_d = {serial_in, sh_q[WIDTH-1:1]};
      if (cnt_q == LAST_BIT) begin
        cnt_d    = '0;
        wordDone = 1'b1;
        state_d  = IDLE;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        state_d = COLLECT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
    end
  end

  // COLLECT is held exactly while cnt is non-zero.
  assign busy = (state_q == COLLECT);

  s2p_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load_i   (wordDone),
    .data_i   (sh_d),
    .ready_i  (out_ready),
    .clr_i    (overrun_clr),
    .data_o   (parallel_out),
    .valid_o  (out_valid),
    .overrun_o(overrun)
  );

endmodule

// File: tb/tb_serial_to_parallel.sv
// Self-checking bench for serial_to_parallel: directed scenarios followed by
// random traffic, all compared against a queue-based word model.
module tb_serial_to_parallel;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         serial_in;
  logic         serial_valid;
  logic         out_ready;
  logic         overrun_clr;
  logic [W-1:0] parallel_out;
  logic         out_valid;
  logic         busy;
  logic         overrun;

  int testsRun = 0;
  int testsFailed = 0;

  bit           mBits[$];
  logic [W-1:0] mData;
  bit           mValid;
  bit           mOver;

  serial_to_parallel #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .serial_in   (serial_in),
    .serial_valid(serial_valid),
    .out_ready   (out_ready),
    .overrun_clr (overrun_clr),
    .parallel_out(parallel_out),
    .out_valid   (out_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    assert (got === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".parallel_out"}, 32'(parallel_out), 32'(mData));
    checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(mValid));
    checkOutput({tag, ".busy"}, 32'(busy), 32'(mBits.size() != 0));
    checkOutput({tag, ".overrun"}, 32'(overrun), 32'(mOver));
  endtask

  task automatic modelReset();
    mBits.delete();
    mData  = '0;
    mValid = 1'b0;
    mOver  = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model across the clock edge, check.
  task automatic applyStimulus(input bit sin, input bit sv, input bit rdy, input bit clr,
                               input string tag);
    int  wordVal;
    bit  done;
    bit  consumed;
    bit  dropped;
    serial_in    = sin;
    serial_valid = sv;
    out_ready    = rdy;
    overrun_clr  = clr;
    @(posedge clk);
    done     = 1'b0;
    dropped  = 1'b0;
    wordVal  = 0;
    consumed = mValid && rdy;
    if (sv) begin
      mBits.push_back(sin);
      if (mBits.size() == W) begin
        done = 1'b1;
        foreach (mBits[i]) wordVal = wordVal + (int'(mBits[i]) << i);
        mBits.delete();
      end
    end
    if (done) begin
      if (!mValid || consumed) begin
        mData  = W'(wordVal);
        mValid = 1'b1;
      end else begin
        dropped = 1'b1;
        mOver   = 1'b1;
      end
    end else if (consumed) begin
      mValid = 1'b0;
    end
    if (clr && !dropped) mOver = 1'b0;
    #1;
    checkAll(tag);
  endtask

  task automatic sendWord(input logic [W-1:0] word, input bit rdy, input string tag);
    for (int i = 0; i < W; i++) applyStimulus(word[i], 1'b1, rdy, 1'b0, tag);
  endtask

  task automatic pulseReset(input string tag);
    rst = 1'b1;
    #2;
    modelReset();
    checkAll(tag);
    #2;
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, {tag, ".after"});
  endtask

  initial begin
    rst          = 1'b1;
    serial_in    = 1'b0;
    serial_valid = 1'b0;
    out_ready    = 1'b0;
    overrun_clr  = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.parallel_out", 32'(parallel_out), 32'h0);
    checkOutput("reset.out_valid", 32'(out_valid), 32'h0);
    checkOutput("reset.busy", 32'(busy), 32'h0);
    checkOutput("reset.overrun", 32'(overrun), 32'h0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "idle");

    // Single word 1,0,1,1 with consumer ready.
    sendWord(4'hD, 1'b1, "wordD");
    checkOutput("wordD.value", 32'(parallel_out), 32'hD);
    checkOutput("wordD.valid", 32'(out_valid), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "wordD.drain");
    checkOutput("wordD.validDrop", 32'(out_valid), 32'h0);

    // Same word with two idle cycles after every bit.
    for (int i = 0; i < W; i++) begin
      applyStimulus(i != 1, 1'b1, 1'b1, 1'b0, "gap.bit");
      if (i != W - 1) begin
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "gap.idle");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "gap.idle");
        checkOutput("gap.busyHeld", 32'(busy), 32'h1);
      end
    end
    checkOutput("gap.value", 32'(parallel_out), 32'hD);

    // Back-to-back words with no bubbles.
    sendWord(4'hA, 1'b1, "b2bA");
    checkOutput("b2bA.value", 32'(parallel_out), 32'hA);
    sendWord(4'h5, 1'b1, "b2b5");
    checkOutput("b2b5.value", 32'(parallel_out), 32'h5);
    checkOutput("b2b5.overrun", 32'(overrun), 32'h0);

    // Consumer stalled: second word is dropped and overrun latches.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "stall.drain");
    sendWord(4'h3, 1'b0, "stall3");
    sendWord(4'hC, 1'b0, "stallC");
    checkOutput("stall.value", 32'(parallel_out), 32'h3);
    checkOutput("stall.overrun", 32'(overrun), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "stall.clr");
    checkOutput("stall.cleared", 32'(overrun), 32'h0);

    // Word 3 consumed in the very cycle word 9 completes.
    for (int i = 0; i < W - 1; i++) applyStimulus(4'h9 >> i, 1'b1, 1'b0, 1'b0, "swap9");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, "swap9.last");
    checkOutput("swap.value", 32'(parallel_out), 32'h9);
    checkOutput("swap.valid", 32'(out_valid), 32'h1);
    checkOutput("swap.overrun", 32'(overrun), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "swap.drain");

    // Reset in the middle of a word.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "midrst.bit");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "midrst.bit");
    pulseReset("midrst");
    sendWord(4'h6, 1'b1, "post6");
    checkOutput("post6.value", 32'(parallel_out), 32'h6);

    // Random traffic, including overrun events that coincide with clears.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 7) == 0), "rand");
      if (n == 200) pulseReset("randrst");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
